// File: rtl/motion_engine.sv
// Per-frame physics stepper for N_OBJ objects: gravity, map-probed wall collisions and screen bounds.
// Zero-wait map: 4 cycles per enabled object, 1 per disabled, plus DONE; cmd_ready only in IDLE, probes wait on map_ack.
module motion_engine #(
    parameter int IDW     = 2,
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int VW      = 6,
    parameter int GRAVITY = 1,
    parameter int VY_MAX  = 15,
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     frame_tick,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [IDW-1:0]           cmd_id,
    input  logic [XW-1:0]            cmd_x,
    input  logic [YW-1:0]            cmd_y,
    input  logic [VW-1:0]            cmd_vx,
    input  logic [VW-1:0]            cmd_vy,
    input  logic                     cmd_grav,
    output logic                     map_req,
    output logic [XW-1:0]            map_x,
    output logic [YW-1:0]            map_y,
    input  logic                     map_ack,
    input  logic                     map_solid,
    output logic [(1<<IDW)-1:0]      obj_en,
    output logic [(1<<IDW)*XW-1:0]   obj_x,
    output logic [(1<<IDW)*YW-1:0]   obj_y,
    output logic                     busy,
    output logic                     done,
    output logic                     hit_pulse,
    output logic [IDW-1:0]           hit_id,
    output logic [XW-1:0]            hit_x,
    output logic [YW-1:0]            hit_y,
    output logic                     overrun
);

    localparam int N_OBJ = 1 << IDW;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PROBE_X, S_PROBE_Y, S_COMMIT, S_DONE
    } state_t;

    state_t             state_q;
    logic [IDW-1:0]     idx_q;
    logic [N_OBJ-1:0]   en_q, grav_q;
    logic [XW-1:0]      x_q  [N_OBJ];
    logic [YW-1:0]      y_q  [N_OBJ];
    logic [VW-1:0]      vx_q [N_OBJ];
    logic [VW-1:0]      vy_q [N_OBJ];

    // Working copy of the object being stepped; written back only at COMMIT.
    logic [XW-1:0]      wx_q;
    logic [YW-1:0]      wy_q;
    logic [VW-1:0]      wvx_q, wvy_q;
    logic               wen_q, wgrav_q, vy_zero_q;

    logic               pending_q, overrun_q, busy_q, done_q, hit_pulse_q, map_req_q;
    logic [XW-1:0]      map_x_q, hit_x_q;
    logic [YW-1:0]      map_y_q, hit_y_q;
    logic [IDW-1:0]     hit_id_q;

    function automatic logic signed [XW:0] step_x(input logic [XW-1:0] p, input logic [VW-1:0] v);
        return $signed({1'b0, p}) + $signed({{(XW+1-VW){v[VW-1]}}, v});
    endfunction

    function automatic logic signed [YW:0] step_y(input logic [YW-1:0] p, input logic [VW-1:0] v);
        return $signed({1'b0, p}) + $signed({{(YW+1-VW){v[VW-1]}}, v});
    endfunction

    function automatic logic oob_x(input logic signed [XW:0] c);
        return c[XW] || (c > (XW+1)'(X_MAX));
    endfunction

    function automatic logic oob_y(input logic signed [YW:0] c);
        return c[YW] || (c > (YW+1)'(Y_MAX));
    endfunction

    function automatic logic [XW-1:0] clamp_x(input logic signed [XW:0] c);
        return c[XW] ? '0 : ((c > (XW+1)'(X_MAX)) ? XW'(X_MAX) : c[XW-1:0]);
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic signed [YW:0] c);
        return c[YW] ? '0 : ((c > (YW+1)'(Y_MAX)) ? YW'(Y_MAX) : c[YW-1:0]);
    endfunction

    logic signed [XW:0] ld_cx, px_cx;
    logic signed [YW:0] cy;
    logic               px_oob, py_oob, px_res, py_res, px_solid, py_solid, last_obj;
    logic [XW-1:0]      x_post;
    logic signed [VW:0] vy_inc;
    logic [VW-1:0]      vy_next;

    always_comb begin
        ld_cx    = step_x(x_q[idx_q], vx_q[idx_q]);
        px_cx    = step_x(wx_q, wvx_q);
        cy       = step_y(wy_q, wvy_q);
        px_oob   = oob_x(px_cx);
        py_oob   = oob_y(cy);
        // Out-of-range candidates resolve as solid without a map transaction.
        px_res   = px_oob || (map_req_q && map_ack);
        py_res   = py_oob || (map_req_q && map_ack);
        px_solid = px_oob || map_solid;
        py_solid = py_oob || map_solid;
        x_post   = px_solid ? wx_q : px_cx[XW-1:0];
        vy_inc   = $signed({wvy_q[VW-1], wvy_q}) + (VW+1)'(GRAVITY);
        vy_next  = (vy_inc > (VW+1)'(VY_MAX)) ? VW'(VY_MAX) : vy_inc[VW-1:0];
        last_obj = (idx_q == IDW'(N_OBJ - 1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            en_q        <= '0;
            grav_q      <= '0;
            for (int i = 0; i < N_OBJ; i++) begin
                x_q[i]  <= '0;
                y_q[i]  <= '0;
                vx_q[i] <= '0;
                vy_q[i] <= '0;
            end
            wx_q        <= '0;
            wy_q        <= '0;
            wvx_q       <= '0;
            wvy_q       <= '0;
            wen_q       <= 1'b0;
            wgrav_q     <= 1'b0;
            vy_zero_q   <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_pulse_q <= 1'b0;
            map_req_q   <= 1'b0;
            map_x_q     <= '0;
            map_y_q     <= '0;
            hit_id_q    <= '0;
            hit_x_q     <= '0;
            hit_y_q     <= '0;
        end else begin
            done_q      <= 1'b0;
            hit_pulse_q <= 1'b0;
            if (frame_tick && state_q != S_IDLE) begin
                if (pending_q) overrun_q <= 1'b1;
                else           pending_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            2'b00: begin
                                en_q[cmd_id]   <= 1'b1;
                                grav_q[cmd_id] <= cmd_grav;
                                x_q[cmd_id]    <= cmd_x;
                                y_q[cmd_id]    <= cmd_y;
                                vx_q[cmd_id]   <= cmd_vx;
                                vy_q[cmd_id]   <= cmd_vy;
                            end
                            2'b01:   vx_q[cmd_id] <= cmd_vx;
                            2'b10:   vy_q[cmd_id] <= cmd_vy;
                            default: en_q[cmd_id] <= 1'b0;
                        endcase
                    end
                    if (frame_tick || pending_q) begin
                        state_q   <= S_LOAD;
                        idx_q     <= '0;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                S_LOAD: begin
                    wx_q      <= x_q[idx_q];
                    wy_q      <= y_q[idx_q];
                    wvx_q     <= vx_q[idx_q];
                    wvy_q     <= vy_q[idx_q];
                    wen_q     <= en_q[idx_q];
                    wgrav_q   <= grav_q[idx_q];
                    vy_zero_q <= 1'b0;
                    if (!en_q[idx_q]) begin
                        if (last_obj) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + IDW'(1);
                        end
                    end else begin
                        state_q   <= S_PROBE_X;
                        map_req_q <= !oob_x(ld_cx);
                        map_x_q   <= ld_cx[XW-1:0];
                        map_y_q   <= y_q[idx_q];
                    end
                end

                S_PROBE_X: begin
                    if (px_res) begin
                        if (px_solid && !wgrav_q) begin
                            wen_q       <= 1'b0;
                            hit_pulse_q <= 1'b1;
                            hit_id_q    <= idx_q;
                            hit_x_q     <= clamp_x(px_cx);
                            hit_y_q     <= wy_q;
                            map_req_q   <= 1'b0;
                            state_q     <= S_COMMIT;
                        end else begin
                            if (px_solid) wvx_q <= '0;
                            else          wx_q  <= px_cx[XW-1:0];
                            // Y probe is issued back-to-back from the post-X position.
                            map_req_q <= !py_oob;
                            map_x_q   <= x_post;
                            map_y_q   <= cy[YW-1:0];
                            state_q   <= S_PROBE_Y;
                        end
                    end
                end

                S_PROBE_Y: begin
                    if (py_res) begin
                        map_req_q <= 1'b0;
                        state_q   <= S_COMMIT;
                        if (!py_solid) begin
                            wy_q <= cy[YW-1:0];
                        end else if (wgrav_q) begin
                            wvy_q     <= '0;
                            vy_zero_q <= 1'b1;
                        end else begin
                            wen_q       <= 1'b0;
                            hit_pulse_q <= 1'b1;
                            hit_id_q    <= idx_q;
                            hit_x_q     <= wx_q;
                            hit_y_q     <= clamp_y(cy);
                        end
                    end
                end

                S_COMMIT: begin
                    x_q[idx_q]  <= wx_q;
                    y_q[idx_q]  <= wy_q;
                    vx_q[idx_q] <= wvx_q;
                    vy_q[idx_q] <= (wgrav_q && wen_q && !vy_zero_q) ? vy_next : wvy_q;
                    en_q[idx_q] <= wen_q;
                    if (last_obj) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + IDW'(1);
                        state_q <= S_LOAD;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign map_req   = map_req_q;
    assign map_x     = map_x_q;
    assign map_y     = map_y_q;
    assign obj_en    = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign hit_pulse = hit_pulse_q;
    assign hit_id    = hit_id_q;
    assign hit_x     = hit_x_q;
    assign hit_y     = hit_y_q;
    assign overrun   = overrun_q;

    for (genvar g = 0; g < N_OBJ; g++) begin : g_obj_out
        assign obj_x[g*XW +: XW] = x_q[g];
        assign obj_y[g*YW +: YW] = y_q[g];
    end

endmodule

// File: tb/tb_motion_engine.sv
// Randomised and directed bench for motion_engine against a per-pass arithmetic model.
module tb_motion_engine;
    localparam int IDW = 2, N = 4, XW = 10, YW = 9, VW = 6;
    localparam int XMAX = 639, YMAX = 479, VYMAX = 15, GRAV = 1;

    logic clk = 1'b0, rstn = 1'b0, frame_tick = 1'b0, cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [IDW-1:0] cmd_id = '0;
    logic [XW-1:0] cmd_x = '0;
    logic [YW-1:0] cmd_y = '0;
    logic [VW-1:0] cmd_vx = '0, cmd_vy = '0;
    logic cmd_grav = 1'b0;
    logic map_req, map_ack, map_solid;
    logic [XW-1:0] map_x;
    logic [YW-1:0] map_y;
    logic [N-1:0] obj_en;
    logic [N*XW-1:0] obj_x;
    logic [N*YW-1:0] obj_y;
    logic busy, done, hit_pulse, overrun;
    logic [IDW-1:0] hit_id;
    logic [XW-1:0] hit_x;
    logic [YW-1:0] hit_y;

    motion_engine #(.IDW(IDW), .XW(XW), .YW(YW), .VW(VW), .GRAVITY(GRAV), .VY_MAX(VYMAX),
                    .X_MAX(XMAX), .Y_MAX(YMAX)) dut (
        .clk(clk), .rstn(rstn), .frame_tick(frame_tick),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_id(cmd_id),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_vx(cmd_vx), .cmd_vy(cmd_vy), .cmd_grav(cmd_grav),
        .map_req(map_req), .map_x(map_x), .map_y(map_y), .map_ack(map_ack), .map_solid(map_solid),
        .obj_en(obj_en), .obj_x(obj_x), .obj_y(obj_y), .busy(busy), .done(done),
        .hit_pulse(hit_pulse), .hit_id(hit_id), .hit_x(hit_x), .hit_y(hit_y), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Map ROM: walls at x >= wall_x or y >= wall_y, ack after ack_delay request cycles.
    int wall_x = 2000, wall_y = 2000, ack_delay = 0, req_cnt = 0;
    logic spur_en = 1'b0, spur = 1'b0;
    always @(posedge clk) req_cnt <= (!map_req || map_ack) ? 0 : req_cnt + 1;
    always @(negedge clk) spur <= spur_en && ($urandom_range(0, 1) == 1);
    assign map_ack   = map_req ? (req_cnt == ack_delay) : spur;
    assign map_solid = map_req ? ((int'(map_x) >= wall_x) || (int'(map_y) >= wall_y)) : spur;

    int hit_seen = 0, bad_req = 0;
    always @(negedge clk) begin
        if (hit_pulse) hit_seen++;
        if (map_req && (int'(map_x) > XMAX || int'(map_y) > YMAX)) bad_req++;
    end

    int n_checks = 0, n_fail = 0;
    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int m_en[N], m_x[N], m_y[N], m_vx[N], m_vy[N], m_g[N];
    int m_hit_id = 0, m_hit_x = 0, m_hit_y = 0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_g[i] = 0;
        end
        m_hit_id = 0; m_hit_x = 0; m_hit_y = 0;
    endtask

    task automatic model_cmd(input int op, input int id, input int x, input int y,
                             input int vx, input int vy, input int g);
        case (op)
            0: begin m_en[id] = 1; m_x[id] = x; m_y[id] = y; m_vx[id] = vx; m_vy[id] = vy; m_g[id] = g; end
            1: m_vx[id] = vx;
            2: m_vy[id] = vy;
            default: m_en[id] = 0;
        endcase
    endtask

    function automatic bit solid_at(input int x, input int y);
        return x < 0 || x > XMAX || y < 0 || y > YMAX || x >= wall_x || y >= wall_y;
    endfunction

    function automatic int clampi(input int v, input int mx);
        return v < 0 ? 0 : (v > mx ? mx : v);
    endfunction

    // One frame over all objects; lat is the expected tick-to-done cycle count with a zero-wait map.
    task automatic model_pass(output int lat, output int hits);
        lat = 1; hits = 0;
        for (int i = 0; i < N; i++) begin
            int cx, cy;
            bit zeroed;
            zeroed = 0;
            if (m_en[i] == 0) begin lat += 1; continue; end
            cx = m_x[i] + m_vx[i];
            if (solid_at(cx, m_y[i])) begin
                if (m_g[i] != 0) m_vx[i] = 0;
                else begin
                    m_en[i] = 0; hits++; lat += 3;
                    m_hit_id = i; m_hit_x = clampi(cx, XMAX); m_hit_y = m_y[i];
                    continue;
                end
            end else m_x[i] = cx;
            lat += 4;
            cy = m_y[i] + m_vy[i];
            if (solid_at(m_x[i], cy)) begin
                if (m_g[i] != 0) begin m_vy[i] = 0; zeroed = 1; end
                else begin
                    m_en[i] = 0; hits++;
                    m_hit_id = i; m_hit_x = m_x[i]; m_hit_y = clampi(cy, YMAX);
                end
            end else m_y[i] = cy;
            if (m_g[i] != 0 && m_en[i] != 0 && !zeroed)
                m_vy[i] = (m_vy[i] + GRAV > VYMAX) ? VYMAX : m_vy[i] + GRAV;
        end
    endtask

    task automatic compare_all(input int exp_lat, input int lat, input int exp_hits,
                               input int got_hits, input bit chk_lat);
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("en%0d", i), int'(obj_en[i]), m_en[i]);
            check_eq($sformatf("x%0d", i), int'(obj_x[i*XW +: XW]), m_x[i]);
            check_eq($sformatf("y%0d", i), int'(obj_y[i*YW +: YW]), m_y[i]);
        end
        check_eq("hit_id", int'(hit_id), m_hit_id);
        check_eq("hit_x", int'(hit_x), m_hit_x);
        check_eq("hit_y", int'(hit_y), m_hit_y);
        check_eq("hit_pulses", got_hits, exp_hits);
        if (chk_lat) check_eq("pass_latency", lat, exp_lat);
    endtask

    task automatic send_cmd(input int op, input int id, input int x, input int y,
                            input int vx, input int vy, input int g);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        cmd_op = op[1:0]; cmd_id = id[IDW-1:0]; cmd_x = x[XW-1:0]; cmd_y = y[YW-1:0];
        cmd_vx = vx[VW-1:0]; cmd_vy = vy[VW-1:0]; cmd_grav = g[0]; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        model_cmd(op, id, x, y, vx, vy, g);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 3000) begin @(negedge clk); lat++; end
        check_eq("done_seen", int'(done), 1);
    endtask

    task automatic do_tick(input bit chk_lat);
        int lat, exp_lat, hits, h0;
        h0 = hit_seen;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        wait_done(lat);
        model_pass(exp_lat, hits);
        @(negedge clk);
        check_eq("busy_after_done", int'(busy), 0);
        compare_all(exp_lat, lat, hits, hit_seen - h0, chk_lat);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, exp_lat, hits, h0, n;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_obj_en", int'(obj_en), 0);
        check_eq("rst_obj_x", int'(obj_x[XW-1:0]), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_map_req", int'(map_req), 0);
        check_eq("rst_overrun", int'(overrun), 0);
        check_eq("rst_hit_id", int'(hit_id), 0);
        check_eq("rst_ready", int'(cmd_ready), 1);
        rstn = 1'b1;

        // Gravity object drifting right in a clear map.
        send_cmd(0, 0, 100, 100, 2, 0, 1);
        do_tick(1);
        do_tick(1);
        // Non-gravity object running into a wall column at x >= 615.
        send_cmd(3, 0, 0, 0, 0, 0, 0);
        wall_x = 615;
        send_cmd(0, 1, 610, 200, 3, 0, 0);
        do_tick(1);
        do_tick(1);
        // Left-edge bound with gravity saturation.
        wall_x = 2000;
        send_cmd(0, 2, 1, 50, -3, 14, 1);
        do_tick(1);
        do_tick(1);
        do_tick(1);
        check_eq("no_oob_req", bad_req, 0);
        // Landing on a floor at y >= 300.
        wall_y = 300;
        send_cmd(0, 3, 300, 297, 0, 5, 1);
        do_tick(1);
        do_tick(1);

        spur_en = 1'b1;
        for (int it = 0; it < 25; it++) begin
            int nc, op;
            nc = $urandom_range(1, 3);
            for (int k = 0; k < nc; k++) begin
                op = $urandom_range(0, 5);
                if (op > 3) op = 0;
                send_cmd(op, $urandom_range(0, N - 1), $urandom_range(0, XMAX), $urandom_range(0, YMAX),
                         int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
                         $urandom_range(0, 1));
            end
            wall_x = $urandom_range(300, 1200);
            wall_y = $urandom_range(200, 900);
            ack_delay = $urandom_range(0, 3);
            do_tick(ack_delay == 0);
        end
        spur_en = 1'b0;
        check_eq("no_oob_req_rand", bad_req, 0);

        // Slow map, queued tick, dropped tick, and a command held across the pass.
        ack_delay = 10; wall_x = 2000; wall_y = 2000;
        for (int i = 0; i < N; i++) send_cmd(3, i, 0, 0, 0, 0, 0);
        send_cmd(0, 0, 100, 100, 1, 0, 1);
        h0 = hit_seen;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        check_eq("overrun_after_one_pending", int'(overrun), 0);
        repeat (2) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        check_eq("overrun_set", int'(overrun), 1);
        check_eq("ready_low_in_pass", int'(cmd_ready), 0);
        cmd_op = 2'b01; cmd_id = '0; cmd_vx = 6'd5; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        check_eq("held_cmd_ready", int'(cmd_ready), 1);
        model_pass(exp_lat, hits);
        model_cmd(1, 0, 0, 0, 5, 0, 0);
        @(negedge clk); cmd_valid = 1'b0;
        check_eq("repass_busy", int'(busy), 1);
        wait_done(lat);
        model_pass(exp_lat, n);
        @(negedge clk);
        compare_all(exp_lat, lat, hits + n, hit_seen - h0, 1'b0);
        check_eq("overrun_sticky", int'(overrun), 1);

        // Reset while the first object is in its Y probe.
        send_cmd(0, 2, 200, 200, 1, 1, 1);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (13) @(negedge clk);
        check_eq("req_before_rst", int'(map_req), 1);
        #2 rstn = 1'b0;
        #1;
        check_eq("arst_map_req", int'(map_req), 0);
        check_eq("arst_busy", int'(busy), 0);
        check_eq("arst_obj_en", int'(obj_en), 0);
        check_eq("arst_overrun", int'(overrun), 0);
        check_eq("arst_hit_x", int'(hit_x), 0);
        check_eq("arst_ready", int'(cmd_ready), 1);
        model_reset();
        @(negedge clk); rstn = 1'b1;
        ack_delay = 0;
        send_cmd(0, 3, 50, 60, 4, -2, 0);
        do_tick(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
